xor_xnor_accum: RTL and testbench
=================================

Name: xor_xnor_accum

Overview:
Streaming bitwise XOR/XNOR accumulator, parametrised in width and frame length. It is the sequential successor to the single-bit mux-built XOR gate. Each frame of WIDTH-bit beats is folded into one accumulated word, optionally inverted (XNOR), along with reduction parity, beat count and overflow flag. It sits between a valid/ready producer and consumer on the data-integrity path.

Parameters:
WIDTH, 8, data/accumulator width in bits (>=1)
MAX_LEN, 16, maximum beats per frame (>=2); count width CW = $clog2(MAX_LEN+1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
mode  input  1  0 = XOR, 1 = XNOR; sampled only on a frame's first accepted beat
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  input beat
in_last  input  1  final beat of frame
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  accumulated word: acc (XOR) or ~acc (XNOR)
out_parity  output  1  ^out_data
out_count  output  CW  beats folded into this result (1..MAX_LEN)
out_overflow  output  1  frame force-terminated at MAX_LEN without in_last

Behaviour:
- Reset (async assert, sync release): state=IDLE; acc, cnt, mode_q, overflow regs = 0. out_valid=0, out_data=0, out_parity=0, out_count=0, out_overflow=0. in_ready=0 while rst high.
- Beat accepted when in_valid && in_ready at rising clk. Result accepted when out_valid && out_ready.
- FSM states: IDLE, ACCUM, DONE. in_ready=1 in IDLE/ACCUM, 0 in DONE. out_valid=1 only in DONE.
- IDLE, beat accepted: acc<=in_data, cnt<=1, mode_q<=mode, ovf<=0.
  - in_last=1 -> DONE, else -> ACCUM.
- ACCUM, beat accepted: acc<=acc^in_data, cnt<=cnt+1.
  - in_last=1 -> DONE, ovf<=0.
  - else if cnt+1==MAX_LEN -> DONE, ovf<=1 (forced termination).
  - else stay in ACCUM.
- ACCUM with no beat: hold all regs, no timeout.
- DONE: outputs driven from regs. out_data = mode_q ? ~acc : acc. out_parity = ^out_data. out_count = cnt. out_overflow = ovf.
  - All outputs held stable while out_ready=0.
  - On result accepted -> IDLE.
- Latency: out_valid rises the cycle after the last/forced beat is accepted. Minimum gap between frames: one DONE cycle, then next beat accepted in IDLE or later.
- Overflow: beats after forced termination start a new frame. An in_last arriving later terminates that new frame normally.
- mode changes after the first beat of a frame are ignored. in_data/in_last are ignored when not accepted, including while in DONE.
- out_data/out_parity/out_count/out_overflow are don't-care when out_valid=0, but they are 0 after reset.
- Reset mid-frame or mid-DONE discards partial result immediately (async). No output handshake completes.
- Arithmetic is pure bitwise XOR, WIDTH bits, no carries. cnt never exceeds MAX_LEN.

Test Plan:
1. WIDTH=8, MAX_LEN=4, mode=0, one beat 0xA5 with in_last -> next cycle out_valid=1, out_data=0xA5, out_parity=0, out_count=1, out_overflow=0.
2. mode=1, beats 0x0F, 0xF0, 0x3C (last on third) -> out_data=0x3C (~0xC3), out_parity=0, out_count=3, out_overflow=0.
3. No in_last, beats 0x01, 0x02, 0x04, 0x08, then 0x10 with last:
   - first result 0x0F, count=4, overflow=1;
   - after handshake, second result 0x10, count=1, overflow=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 -> out_valid and outputs stable, in_ready=0, no beat absorbed. On out_ready=1 -> IDLE, next beat accepted.
5. mode=0 on first beat 0x11, then mode=1 on last beat 0x22 -> out_data=0x33 (XOR retained), out_parity=0.
6. Pulse rst asynchronously between edges after two beats of a frame:
   - out_valid=0 and in_ready=0 immediately;
   - after release, single-beat 0x55 with last, mode=0 -> out_data=0x55, out_count=1.

Source files
------------

// File: rtl/xor_xnor_accum.sv
// Streaming XOR/XNOR frame accumulator.
// Each frame of beats is folded into one word with bitwise XOR. The word is
// inverted for XNOR frames and presented with its parity, beat count and a
// flag that shows the frame was cut off at MAX_LEN.
module xor_xnor_accum #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_LEN = 16,
   localparam int unsigned CW     = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_parity,
   output logic [CW-1:0]    out_count,
   output logic             out_overflow
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] acc, acc_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             mode_q, mode_nx;
   logic             ovf, ovf_nx;
   logic             beat_ok;

   // State and datapath registers; reset discards any partial frame or result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         cnt    <= '0;
         mode_q <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         state  <= state_nx;
         acc    <= acc_nx;
         cnt    <= cnt_nx;
         mode_q <= mode_nx;
         ovf    <= ovf_nx;
      end
   end

   // Handshakes, frame folding, next-state selection and result presentation.
   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      cnt_nx   = cnt;
      mode_nx  = mode_q;
      ovf_nx   = ovf;

      in_ready  = (state != DONE) && !rst;
      out_valid = (state == DONE);
      beat_ok   = in_valid && in_ready;

      unique case (state)
         IDLE: begin
            if (beat_ok) begin
               acc_nx   = in_data;
               cnt_nx   = CW'(1);
               mode_nx  = mode;
               ovf_nx   = 1'b0;
               state_nx = in_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (beat_ok) begin
               acc_nx = acc ^ in_data;
               cnt_nx = cnt + CW'(1);
               if (in_last) begin
                  state_nx = DONE;
                  ovf_nx   = 1'b0;
               end else if (cnt_nx == CW'(MAX_LEN)) begin
                  // frame cut off: the next beat opens a fresh frame
                  state_nx = DONE;
                  ovf_nx   = 1'b1;
               end
            end
         end
         DONE: begin
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      out_data     = mode_q ? ~acc : acc;
      out_parity   = ^out_data;
      out_count    = cnt;
      out_overflow = ovf;
   end

endmodule

// File: tb/tb_xor_xnor_accum.sv
// Bench for xor_xnor_accum: directed frames with literal results, then random
// traffic checked every cycle against a frame-level reference model.
module tb_xor_xnor_accum;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned MAX_LEN = 4;
   localparam int unsigned CW      = $clog2(MAX_LEN + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             mode = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             out_parity;
   logic [CW-1:0]    out_count;
   logic             out_overflow;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   xor_xnor_accum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .rst(rst), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_parity(out_parity), .out_count(out_count), .out_overflow(out_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: frames kept as lists of beats, folded when complete.
   logic [WIDTH-1:0] frame_q[$];
   bit               frame_mode = 1'b0;
   bit               pend = 1'b0;
   logic [WIDTH-1:0] exp_data = '0;
   int unsigned      exp_cnt = 0;
   bit               exp_ovf = 1'b0;
   logic [WIDTH-1:0] fold;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q.delete();
         pend = 1'b0;
         frame_mode = 1'b0;
      end else if (pend) begin
         if (out_ready) pend = 1'b0;
      end else if (in_valid) begin
         if (frame_q.size() == 0) frame_mode = mode;
         frame_q.push_back(in_data);
         if (in_last || frame_q.size() == MAX_LEN) begin
            fold = '0;
            foreach (frame_q[i]) fold = fold ^ frame_q[i];
            exp_data = frame_mode ? ~fold : fold;
            exp_cnt  = frame_q.size();
            exp_ovf  = !in_last;
            pend     = 1'b1;
            frame_q.delete();
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("in_ready", 32'(in_ready), 32'(!pend && !rst));
      chk("out_valid", 32'(out_valid), 32'(pend));
      if (pend) begin
         chk("out_data", 32'(out_data), 32'(exp_data));
         chk("out_parity", 32'(out_parity), 32'($countones(exp_data) % 2));
         chk("out_count", 32'(out_count), exp_cnt);
         chk("out_overflow", 32'(out_overflow), 32'(exp_ovf));
      end
   end

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send(input logic [WIDTH-1:0] d, input logic l, input logic m);
      int unsigned n = 0;
      in_valid = 1'b1; in_data = d; in_last = l; mode = m;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("send_timeout", 32'(n < 50), 32'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      mode     = 1'($urandom_range(0, 1));
   endtask

   // Waits for a result, checks it against literal values, then accepts it.
   task automatic take(input logic [WIDTH-1:0] d, input logic p, input int unsigned c, input logic o);
      int unsigned n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("t_latency", n, 0);
      chk("t_data", 32'(out_data), 32'(d));
      chk("t_parity", 32'(out_parity), 32'(p));
      chk("t_count", 32'(out_count), c);
      chk("t_overflow", 32'(out_overflow), 32'(o));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      #2;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_parity", 32'(out_parity), 0);
      chk("rst_out_count", 32'(out_count), 0);
      chk("rst_out_overflow", 32'(out_overflow), 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;

      // single beat
      send(8'hA5, 1'b1, 1'b0);
      take(8'hA5, 1'b0, 1, 1'b0);

      // XNOR frame of three
      send(8'h0F, 1'b0, 1'b1);
      send(8'hF0, 1'b0, 1'b0);
      send(8'h3C, 1'b1, 1'b0);
      take(8'h3C, 1'b0, 3, 1'b0);

      // forced termination, then a one-beat frame
      send(8'h01, 1'b0, 1'b0);
      send(8'h02, 1'b0, 1'b0);
      send(8'h04, 1'b0, 1'b0);
      send(8'h08, 1'b0, 1'b0);
      take(8'h0F, 1'b0, 4, 1'b1);
      send(8'h10, 1'b1, 1'b0);
      take(8'h10, 1'b1, 1, 1'b0);

      // backpressure with a beat waiting
      send(8'h5A, 1'b1, 1'b0);
      in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1; mode = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_ready", 32'(in_ready), 0);
         chk("bp_data", 32'(out_data), 'h5A);
         chk("bp_count", 32'(out_count), 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_idle_ready", 32'(in_ready), 1);
      chk("bp_idle_valid", 32'(out_valid), 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      take(8'hFF, 1'b0, 1, 1'b0);

      // mode is taken from the first beat only
      send(8'h11, 1'b0, 1'b0);
      send(8'h22, 1'b1, 1'b1);
      take(8'h33, 1'b0, 2, 1'b0);

      // asynchronous reset mid-frame
      send(8'h12, 1'b0, 1'b0);
      send(8'h34, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_in_ready", 32'(in_ready), 0);
      chk("arst_out_count", 32'(out_count), 0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      send(8'h55, 1'b1, 1'b0);
      take(8'h55, 1'b0, 1, 1'b0);

      // random traffic against the model
      repeat (400) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = WIDTH'($urandom);
         in_last   = ($urandom_range(0, 3) == 0);
         mode      = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 9) < 6);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
